// File: rtl/cpu_loader.sv
// Stream loader: decodes section headers, writes instruction words and data
// doublewords into external memories, then enables the CPU for a bounded run.
module cpu_loader #(
    parameter int unsigned RUN_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        enable,
    output logic        done
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD_I,
        S_LOAD_D_LO,
        S_LOAD_D_HI,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0] LP_RUN_LAST = RUN_CYCLES - 1;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_in_ready;
    logic        w_xfer;
    logic        w_last_word;
    logic        w_run_last;
    logic [15:0] r_index;
    logic [15:0] r_remaining;
    logic [31:0] r_low;
    logic [31:0] r_run_cnt;
    logic [63:0] r_addr_i;
    logic        r_wen_i;
    logic [31:0] r_wdata_i;
    logic [63:0] r_addr_d;
    logic        r_wen_d;
    logic [63:0] r_wdata_d;
    logic        r_enable;
    logic        r_done;

    assign w_in_ready  = (r_state == S_HDR) || (r_state == S_LOAD_I) ||
                         (r_state == S_LOAD_D_LO) || (r_state == S_LOAD_D_HI);
    assign w_xfer      = in_valid && w_in_ready;
    assign w_last_word = (r_remaining == 16'd1);
    assign w_run_last  = (RUN_CYCLES != 0) && (r_run_cnt == LP_RUN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_xfer) begin
                    if (in_data[15:0] == 16'd0) begin
                        w_state_next = S_RUN;
                    end else if (in_data[31]) begin
                        w_state_next = S_LOAD_D_LO;
                    end else begin
                        w_state_next = S_LOAD_I;
                    end
                end
            end
            S_LOAD_I: begin
                if (w_xfer && w_last_word) begin
                    w_state_next = S_HDR;
                end
            end
            S_LOAD_D_LO: begin
                if (w_xfer) begin
                    w_state_next = S_LOAD_D_HI;
                end
            end
            S_LOAD_D_HI: begin
                if (w_xfer) begin
                    w_state_next = w_last_word ? S_HDR : S_LOAD_D_LO;
                end
            end
            S_RUN: begin
                if (w_run_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_HDR;
        endcase
    end

    // Write strobes are single-cycle pulses; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index     <= 16'd0;
            r_remaining <= 16'd0;
            r_low       <= 32'd0;
            r_run_cnt   <= 32'd0;
            r_addr_i    <= 64'd0;
            r_wen_i     <= 1'b0;
            r_wdata_i   <= 32'd0;
            r_addr_d    <= 64'd0;
            r_wen_d     <= 1'b0;
            r_wdata_d   <= 64'd0;
            r_enable    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wen_i <= 1'b0;
            r_wen_d <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    S_HDR: begin
                        if (in_data[15:0] != 16'd0) begin
                            r_index     <= {1'b0, in_data[30:16]};
                            r_remaining <= in_data[15:0];
                        end
                    end
                    S_LOAD_I: begin
                        r_wen_i     <= 1'b1;
                        r_addr_i    <= {46'd0, r_index, 2'b00};
                        r_wdata_i   <= in_data;
                        r_index     <= r_index + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                    end
                    S_LOAD_D_LO: begin
                        r_low <= in_data;
                    end
                    S_LOAD_D_HI: begin
                        r_wen_d     <= 1'b1;
                        r_addr_d    <= {45'd0, r_index, 3'b000};
                        r_wdata_d   <= {in_data, r_low};
                        r_index     <= r_index + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                    end
                    default: ;
                endcase
            end
            if ((r_state == S_RUN) && (RUN_CYCLES != 0)) begin
                r_run_cnt <= r_run_cnt + 32'd1;
            end
            r_enable <= (w_state_next == S_RUN);
            r_done   <= (w_state_next == S_DONE);
        end
    end

    assign in_ready    = w_in_ready;
    assign addr_ext    = r_addr_i;
    assign wen_ext     = r_wen_i;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = r_wdata_i;
    assign addr_ext_2  = r_addr_d;
    assign wen_ext_2   = r_wen_d;
    assign ren_ext_2   = 1'b0;
    assign wdata_ext_2 = r_wdata_d;
    assign enable      = r_enable;
    assign done        = r_done;

endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: directed table, random sections against an address
// arithmetic model, reset-in-section and bounded-run sequences.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;

    logic        in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, done;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;

    logic        in_ready0, wen_ext0, ren_ext0, wen_ext_20, ren_ext_20, enable0, done0;
    logic [63:0] addr_ext0, addr_ext_20, wdata_ext_20;
    logic [31:0] wdata_ext0;

    cpu_loader #(.RUN_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .addr_ext(addr_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
        .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .enable(enable), .done(done)
    );

    cpu_loader #(.RUN_CYCLES(0)) dut_free (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .addr_ext(addr_ext0), .wen_ext(wen_ext0),
        .ren_ext(ren_ext0), .wdata_ext(wdata_ext0), .addr_ext_2(addr_ext_20),
        .wen_ext_2(wen_ext_20), .ren_ext_2(ren_ext_20), .wdata_ext_2(wdata_ext_20),
        .enable(enable0), .done(done0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        dm;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         act_q[$];
    wr_t         exp_q[$];
    logic [31:0] words_q[$];

    typedef struct {
        logic [31:0]       hdr;
        int                nw;
        logic [3:0][31:0]  w;
        int                ne;
        logic              dm;
        logic [3:0][63:0]  ea;
        logic [3:0][63:0]  ed;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: captures every strobe and checks exclusivity and hold behaviour.
    logic        rst_edge = 1'b1;
    logic [63:0] prev_ai, prev_ad, prev_dd;
    logic [31:0] prev_di;

    always @(posedge clk) rst_edge = rst;

    always @(negedge clk) begin
        if (wen_ext || wen_ext_2) begin
            checks++;
            if (wen_ext && wen_ext_2) begin
                errors++;
                $display("FAIL wen_exclusive: got both strobes high expected at most one");
            end
        end
        if (wen_ext)   act_q.push_back('{1'b0, addr_ext, {32'd0, wdata_ext}});
        if (wen_ext_2) act_q.push_back('{1'b1, addr_ext_2, wdata_ext_2});
        if (!rst_edge && !wen_ext) begin
            checks++;
            if (addr_ext !== prev_ai || wdata_ext !== prev_di) begin
                errors++;
                $display("FAIL hold_imem: got 0x%0h/0x%0h expected 0x%0h/0x%0h",
                         addr_ext, wdata_ext, prev_ai, prev_di);
            end
        end
        if (!rst_edge && !wen_ext_2) begin
            checks++;
            if (addr_ext_2 !== prev_ad || wdata_ext_2 !== prev_dd) begin
                errors++;
                $display("FAIL hold_dmem: got 0x%0h/0x%0h expected 0x%0h/0x%0h",
                         addr_ext_2, wdata_ext_2, prev_ad, prev_dd);
            end
        end
        prev_ai = addr_ext;
        prev_di = wdata_ext;
        prev_ad = addr_ext_2;
        prev_dd = wdata_ext_2;
    end

    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_section(input logic [31:0] hdr, input int max_gap);
        send_word(hdr, $urandom_range(0, max_gap));
        foreach (words_q[i]) send_word(words_q[i], $urandom_range(0, max_gap));
    endtask

    // Expected writes derived from the header fields with plain address arithmetic.
    task automatic model_section(input logic [31:0] hdr);
        int          base, n;
        logic [15:0] idx;
        base = int'(hdr[30:16]);
        n    = int'(hdr[15:0]);
        for (int i = 0; i < n; i++) begin
            idx = 16'((base + i) % 65536);
            if (hdr[31])
                exp_q.push_back('{1'b1, 64'(idx) * 64'd8, {words_q[2*i+1], words_q[2*i]}});
            else
                exp_q.push_back('{1'b0, 64'(idx) * 64'd4, {32'd0, words_q[i]}});
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("%s write %0d: dm=%0d addr=0x%0h data=0x%0h",
                     tag, i, act_q[i].dm, act_q[i].addr, act_q[i].data);
            chk({tag, "_target"}, 64'(act_q[i].dm), 64'(exp_q[i].dm));
            chk({tag, "_addr"}, act_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          en_cnt, en0_cnt;
        logic        dm;
        logic [14:0] base;
        int          n;

        vecs[0].hdr = 32'h0002_0003; vecs[0].nw = 3; vecs[0].ne = 3; vecs[0].dm = 1'b0;
        vecs[0].w  = {32'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        vecs[0].ea = {64'h0, 64'h10, 64'hC, 64'h8};
        vecs[0].ed = {64'h0, 64'hCCCC_0003, 64'hBBBB_0002, 64'hAAAA_0001};
        vecs[1].hdr = 32'h8000_0001; vecs[1].nw = 2; vecs[1].ne = 1; vecs[1].dm = 1'b1;
        vecs[1].w  = {32'h0, 32'h0, 32'h2222_2222, 32'h1111_1111};
        vecs[1].ea = {64'h0, 64'h0, 64'h0, 64'h0};
        vecs[1].ed = {64'h0, 64'h0, 64'h0, 64'h2222_2222_1111_1111};
        vecs[2].hdr = 32'h7FFF_0002; vecs[2].nw = 2; vecs[2].ne = 2; vecs[2].dm = 1'b0;
        vecs[2].w  = {32'h0, 32'h0, 32'h5A5A_0002, 32'hA5A5_0001};
        vecs[2].ea = {64'h0, 64'h0, 64'h2_0000, 64'h1_FFFC};
        vecs[2].ed = {64'h0, 64'h0, 64'h5A5A_0002, 64'hA5A5_0001};
        vecs[3].hdr = 32'h8005_0002; vecs[3].nw = 4; vecs[3].ne = 2; vecs[3].dm = 1'b1;
        vecs[3].w  = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        vecs[3].ea = {64'h0, 64'h0, 64'h30, 64'h28};
        vecs[3].ed = {64'h0, 64'h0, 64'hDDDD_0004_CCCC_0003, 64'hBBBB_0002_AAAA_0001};

        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_wen", 64'({wen_ext, wen_ext_2}), 64'd0);
        chk("reset_addr_ext", addr_ext, 64'd0);
        chk("reset_wdata_ext_2", wdata_ext_2, 64'd0);
        chk("reset_enable_done", 64'({enable, done}), 64'd0);
        chk("ren_constant", 64'({ren_ext, ren_ext_2}), 64'd0);

        for (int v = 0; v < 4; v++) begin
            $display("vector %0d: header 0x%08h", v, vecs[v].hdr);
            words_q.delete();
            for (int i = 0; i < vecs[v].nw; i++) words_q.push_back(vecs[v].w[i]);
            for (int i = 0; i < vecs[v].ne; i++)
                exp_q.push_back('{vecs[v].dm, vecs[v].ea[i], vecs[v].ed[i]});
            send_section(vecs[v].hdr, 0);
            compare_writes($sformatf("vec%0d", v));
            chk("vec_back_in_hdr", 64'(in_ready), 64'd1);
            chk("vec_enable_low", 64'(enable), 64'd0);
        end

        for (int r = 0; r < 8; r++) begin
            dm   = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            base = 15'($urandom_range(0, 32767));
            n    = (r == 0) ? 4 : $urandom_range(1, 4);
            words_q.delete();
            for (int i = 0; i < n * (dm ? 2 : 1); i++) words_q.push_back($urandom);
            $display("random %0d: header 0x%08h", r, {dm, base, 16'(n)});
            model_section({dm, base, 16'(n)});
            send_section({dm, base, 16'(n)}, 4);
            compare_writes($sformatf("rand%0d", r));
        end

        // Reset after the low half of a pair: the pending half must be dropped.
        words_q.delete();
        send_word(32'h8001_0002, 0);
        send_word(32'h1357_9BDF, 0);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h0004_0001;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_addr_ext_2", addr_ext_2, 64'd0);
        chk("midreset_wdata_ext_2", wdata_ext_2, 64'd0);
        repeat (2) @(negedge clk);
        chk("midreset_no_write", 64'(act_q.size()), 64'd0);
        chk("midreset_still_hdr", 64'(in_ready), 64'd1);
        words_q.delete();
        words_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back('{1'b0, 64'hC, 64'hDEAD_BEEF});
        send_section(32'h0003_0001, 0);
        compare_writes("after_reset_i");
        words_q.delete();
        words_q.push_back(32'h0000_00AA);
        words_q.push_back(32'h0000_00BB);
        exp_q.push_back('{1'b1, 64'h8, 64'h0000_00BB_0000_00AA});
        send_section(32'h8001_0001, 0);
        compare_writes("after_reset_d");

        chk("pre_run_enable", 64'(enable), 64'd0);
        send_word(32'h0000_0000, 0);
        en_cnt = 0;
        en0_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            if (enable) en_cnt++;
            if (enable0) en0_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        $display("run: enable cycles=%0d free-run cycles=%0d", en_cnt, en0_cnt);
        chk("run_enable_cycles", 64'(en_cnt), 64'd5);
        chk("run_done", 64'(done), 64'd1);
        chk("run_enable_off", 64'(enable), 64'd0);
        chk("run_in_ready_low", 64'(in_ready), 64'd0);
        chk("run_no_writes", 64'(act_q.size()), 64'd0);
        chk("free_enable_cycles", 64'(en0_cnt), 64'd30);
        chk("free_done_low", 64'(done0), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_sticky", 64'({done, enable, in_ready}), 64'b100);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_run_enable", 64'(enable0), 64'd0);
        chk("reset_done_clear", 64'(done), 64'd0);
        chk("reset_in_run_ready", 64'(in_ready), 64'd1);

        send_word(32'h8005_0000, 0);
        chk("dmem_zero_hdr_run", 64'(enable), 64'd1);
        chk("dmem_zero_hdr_run_free", 64'(enable0), 64'd1);
        chk("dmem_zero_hdr_ready", 64'(in_ready), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 0, meaning number of enabled CPU cycles before auto-stop (0 = run forever).
REQ-002 SHALL have reset synchronous and active-high; one clock.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  loader stream word valid.
REQ-006 SHALL have port in_data  input  32  loader stream word.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port addr_ext  output  64  instruction memory byte address.
REQ-009 SHALL have port wen_ext  output  1  instruction memory write strobe.
REQ-010 SHALL have port ren_ext  output  1  instruction memory read enable, constant 0.
REQ-011 SHALL have port wdata_ext  output  32  instruction memory write word.
REQ-012 SHALL have port addr_ext_2  output  64  data memory byte address.
REQ-013 SHALL have port wen_ext_2  output  1  data memory write strobe.
REQ-014 SHALL have port ren_ext_2  output  1  data memory read enable, constant 0.
REQ-015 SHALL have port wdata_ext_2  output  64  data memory write doubleword.
REQ-016 SHALL have port enable  output  1  CPU run enable.
REQ-017 SHALL have port done  output  1  run finished, sticky until reset.

Function
REQ-018 SHALL accept a word only in a cycle with in_valid=1 and in_ready=1 (a transfer).
REQ-019 SHALL implement states HDR, LOAD_I, LOAD_D_LO, LOAD_D_HI, RUN, DONE.
REQ-020 SHALL drive in_ready=1 in HDR, LOAD_I, LOAD_D_LO and LOAD_D_HI, and 0 in RUN and DONE.
REQ-021 SHALL decode a header transfer in HDR as: bit31 = target (0 imem, 1 dmem), bits30:16 = base word index, bits15:0 = count N.
REQ-022 SHALL, on a header with N=0, go to RUN regardless of target.
REQ-023 SHALL, on a header with N>0, load base into a 16-bit index register, load N into a remaining counter, and go to LOAD_I (target 0) or LOAD_D_LO (target 1).
REQ-024 SHALL, on each LOAD_I transfer of word w at cycle k, drive wen_ext=1, addr_ext=index*4 (zero-extended) and wdata_ext=w in cycle k+1, with wen_ext lasting exactly one cycle.
REQ-025 SHALL, on a LOAD_D_LO transfer, register the word as the low half and go to LOAD_D_HI, with no write issued.
REQ-026 SHALL, on a LOAD_D_HI transfer of word h at cycle k, drive wen_ext_2=1, addr_ext_2=index*8 and wdata_ext_2={h,low} in cycle k+1, then return to LOAD_D_LO.
REQ-027 SHALL, after each write, increment index modulo 2^16 and decrement remaining; when remaining reaches 0, return to HDR.
REQ-028 SHALL hold addr/wdata outputs at their last values while the corresponding wen is 0.
REQ-029 SHALL never assert wen_ext and wen_ext_2 in the same cycle.
REQ-030 SHALL drive enable=1 from the cycle after entering RUN until leaving RUN, and never outside RUN.
REQ-031 SHALL, with RUN_CYCLES>0, count enable-high cycles with a 32-bit counter; after exactly RUN_CYCLES such cycles it SHALL go to DONE (enable=0, done=1).
REQ-032 SHALL, with RUN_CYCLES=0, remain in RUN until reset.
REQ-033 SHALL ignore in_valid in RUN and DONE; DONE is terminal until reset.
REQ-034 SHALL perform no write and no state change for cycles with in_valid=0 (stalls of any length are allowed between words).

Reset
REQ-035 SHALL, when rst=1 at a clock edge, enter HDR and zero all outputs, index, remaining, low-half and run counters.
REQ-036 SHALL give rst priority over any simultaneous transfer; a word presented during reset is not accepted.
REQ-037 SHALL, on reset mid-section, discard any pending low half; on reset in RUN, drop enable in the next cycle.

Verification
REQ-038 SHALL be verified with: header 0x0002_0003 then words A,B,C -> wen_ext pulses at addr 0x8,0xC,0x10 with A,B,C, then back in HDR.
REQ-039 SHALL be verified with: header 0x8000_0001, words 0x11111111, 0x22222222 -> one wen_ext_2 at addr 0x0, data 0x22222222_11111111.
REQ-040 SHALL be verified with: RUN_CYCLES=5, header 0x0000_0000 -> enable high for exactly 5 cycles, then done=1 and in_ready=0 stable.
REQ-041 SHALL be verified with: header 0x7FFF_0002 with base 0x7FFF at max, two imem words -> addrs 0x1FFFC, 0x20000 (index wraps only at 0xFFFF+1).
REQ-042 SHALL be verified with: random in_valid gaps during a 4-word imem load -> same writes and addresses as the gap-free case, one per transfer.
REQ-043 SHALL be verified with: rst asserted after the low half of a dmem pair -> no wen_ext_2, state HDR, next header decoded correctly.
